// File: rtl/enigma_step_if.sv
// Key-in / letter-out handshake bundle for enigma_step_ctrl.
// Valid/ready semantics on both channels: a transfer happens on the rising
// clock edge where valid && ready are both 1. The producer holds valid and
// its payload stable until that edge. The consumer may raise or drop ready
// freely, and ready may depend combinationally on other inputs.
interface enigma_step_if;
  logic       key_valid;
  logic [4:0] key_in;
  logic       key_ready;
  logic       out_valid;
  logic [4:0] out_letter;
  logic       out_ready;

  // Controller side: consumes keys, produces encrypted letters.
  modport slave (
    input  key_valid, key_in, out_ready,
    output key_ready, out_valid, out_letter
  );

  // Environment side: offers keys, accepts encrypted letters.
  modport master (
    output key_valid, key_in, out_ready,
    input  key_ready, out_valid, out_letter
  );
endinterface

// File: rtl/enigma_step_ctrl.sv
// Three-rotor Enigma sequencing controller.
// Owns the rotor offsets, steps them per accepted key (odometer with notch
// carries), drives the key into the external rotor/reflector chain, waits a
// fixed settle time and returns the encrypted letter on a valid/ready port.
// Optional build macro ENIGMA_DOUBLE_STEP_EN enables the historical
// middle-rotor double step; without it the rotors behave as a pure odometer.
// dbg_state_o exposes the FSM state (0 IDLE, 1 STEP, 2 SETTLE, 3 RESULT).
module enigma_step_ctrl #(
  parameter int unsigned NOTCH1        = 16,
  parameter int unsigned NOTCH2        = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [4:0]           load_pos1,
  input  logic [4:0]           load_pos2,
  input  logic [4:0]           load_pos3,
  enigma_step_if.slave         kif,
  output logic                 err_invalid,
  output logic [4:0]           rot1,
  output logic [4:0]           rot2,
  output logic [4:0]           rot3,
  output logic [4:0]           enc_in,
  input  logic [4:0]           enc_result,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STEP   = 2'd1,
    S_SETTLE = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  localparam logic [4:0] N1       = 5'(NOTCH1);
  localparam logic [4:0] N2       = 5'(NOTCH2);
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [4:0] rot1_q, rot1_d;
  logic [4:0] rot2_q, rot2_d;
  logic [4:0] rot3_q, rot3_d;
  logic [4:0] enc_in_q, enc_in_d;
  logic [4:0] out_letter_q, out_letter_d;
  logic       out_valid_q, out_valid_d;
  logic       err_q, err_d;
  logic [3:0] cnt_q, cnt_d;

  logic       key_ready;
  logic       key_hs;
  logic       key_ok;
  logic       carry1;
  logic       mid_at_notch;
  logic       step2;
  logic       step3;

  // Offset increment with explicit compare-and-wrap at 25.
  function automatic logic [4:0] inc26(input logic [4:0] v);
    return (v == 5'd25) ? 5'd0 : v + 5'd1;
  endfunction

  // Fold a raw 5-bit start position into 0..25.
  function automatic logic [4:0] fold26(input logic [4:0] v);
    return (v >= 5'd26) ? v - 5'd26 : v;
  endfunction

  assign key_ready    = (state_q == S_IDLE) && !load;
  assign key_hs       = key_ready && kif.key_valid;
  assign key_ok       = (kif.key_in >= 5'd1) && (kif.key_in <= 5'd26);
  assign carry1       = (rot1_q == N1);
  assign mid_at_notch = (rot2_q == N2);

`ifdef ENIGMA_DOUBLE_STEP_EN
  // Middle rotor sitting on its notch drags itself and rotor 3 along.
  assign step2 = carry1 || mid_at_notch;
  assign step3 = mid_at_notch;
`else
  // Pure odometer: rotor 3 only moves when rotor 1 carries through rotor 2.
  assign step2 = carry1;
  assign step3 = carry1 && mid_at_notch;
`endif

  // Next-state and datapath updates for the sequencing FSM.
  always_comb begin
    state_d      = state_q;
    rot1_d       = rot1_q;
    rot2_d       = rot2_q;
    rot3_d       = rot3_q;
    enc_in_d     = enc_in_q;
    out_letter_d = out_letter_q;
    out_valid_d  = 1'b0;
    err_d        = 1'b0;
    cnt_d        = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          rot1_d = fold26(load_pos1);
          rot2_d = fold26(load_pos2);
          rot3_d = fold26(load_pos3);
        end else if (key_hs) begin
          if (key_ok) begin
            enc_in_d = kif.key_in;
            state_d  = S_STEP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_STEP: begin
        rot1_d  = inc26(rot1_q);
        rot2_d  = step2 ? inc26(rot2_q) : rot2_q;
        rot3_d  = step3 ? inc26(rot3_q) : rot3_q;
        cnt_d   = CNT_INIT;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) begin
          out_letter_d = enc_result;
          state_d      = S_RESULT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESULT: begin
        // out_valid is registered: it rises one cycle after the letter is
        // captured and drops on the edge that completes the transfer.
        if (out_valid_q && kif.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rot1_q       <= 5'd0;
      rot2_q       <= 5'd0;
      rot3_q       <= 5'd0;
      enc_in_q     <= 5'd0;
      out_letter_q <= 5'd0;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      rot1_q       <= rot1_d;
      rot2_q       <= rot2_d;
      rot3_q       <= rot3_d;
      enc_in_q     <= enc_in_d;
      out_letter_q <= out_letter_d;
      out_valid_q  <= out_valid_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign kif.key_ready  = key_ready;
  assign kif.out_valid  = out_valid_q;
  assign kif.out_letter = out_letter_q;
  assign err_invalid    = err_q;
  assign rot1           = rot1_q;
  assign rot2           = rot2_q;
  assign rot3           = rot3_q;
  assign enc_in         = enc_in_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Self-checking bench for enigma_step_ctrl.
// The reference model tracks rotor positions as plain integers with % 26
// arithmetic and the notch rules; directed cases come first, then a
// randomized mix of loads, valid keys and invalid keys.
module tb_enigma_step_ctrl;

  localparam int NOTCH1 = 16;
  localparam int NOTCH2 = 4;
  localparam int SETTLE = 2;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       load;
  logic [4:0] load_pos1, load_pos2, load_pos3;
  logic       err_invalid;
  logic [4:0] rot1, rot2, rot3;
  logic [4:0] enc_in;
  logic [4:0] enc_result;
  logic [1:0] dbg_state;

  enigma_step_if kif();

  enigma_step_ctrl #(
    .NOTCH1(NOTCH1), .NOTCH2(NOTCH2), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load),
    .load_pos1(load_pos1), .load_pos2(load_pos2), .load_pos3(load_pos3),
    .kif(kif), .err_invalid(err_invalid),
    .rot1(rot1), .rot2(rot2), .rot3(rot3),
    .enc_in(enc_in), .enc_result(enc_result), .dbg_state_o(dbg_state)
  );

  // Scoreboard state
  int n_vec = 0;
  int n_bad = 0;
  int m_r1 = 0, m_r2 = 0, m_r3 = 0;
  int m_enc = 0;
  logic [4:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rot(input string tag);
    check({tag, "_rot1"}, 32'(rot1), 32'(m_r1));
    check({tag, "_rot2"}, 32'(rot2), 32'(m_r2));
    check({tag, "_rot3"}, 32'(rot3), 32'(m_r3));
  endtask

  // Reference rotor motion for one accepted key.
  task automatic model_step();
    bit c1, mid, s2, s3;
    c1  = (m_r1 == NOTCH1);
    mid = (m_r2 == NOTCH2);
`ifdef ENIGMA_DOUBLE_STEP_EN
    s2 = c1 || mid;
    s3 = mid;
`else
    s2 = c1;
    s3 = c1 && mid;
`endif
    m_r1 = (m_r1 + 1) % 26;
    if (s2) m_r2 = (m_r2 + 1) % 26;
    if (s3) m_r3 = (m_r3 + 1) % 26;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (kif.key_ready !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    check("key_ready_wait", 32'(kif.key_ready), 32'd1);
  endtask

  // Driver: load start positions, offering a key in the same cycle.
  task automatic do_load(input logic [4:0] p1, input logic [4:0] p2, input logic [4:0] p3);
    wait_ready();
    load          = 1'b1;
    load_pos1     = p1;
    load_pos2     = p2;
    load_pos3     = p3;
    kif.key_valid = 1'($urandom_range(0, 1));
    kif.key_in    = 5'($urandom_range(1, 26));
    tick();
    load          = 1'b0;
    kif.key_valid = 1'b0;
    m_r1 = int'(p1) % 26;
    m_r2 = int'(p2) % 26;
    m_r3 = int'(p3) % 26;
    check_rot("load");
    check("load_state_idle", 32'(dbg_state), 32'd0);
    check("load_enc_in", 32'(enc_in), 32'(m_enc));
  endtask

  // Driver: offer one key, follow it through to the output handshake.
  // hold = cycles of out_ready=0 once out_valid is up; storm toggles the
  // ignored inputs during that hold.
  task automatic do_key(input logic [4:0] k, input logic [4:0] er, input int hold, input bit storm);
    int lat;
    wait_ready();
    kif.key_valid = 1'b1;
    kif.key_in    = k;
    enc_result    = er;
    tick();
    kif.key_valid = 1'b0;
    kif.key_in    = 5'($urandom_range(0, 31));
    if (k >= 5'd1 && k <= 5'd26) begin
      check("accept_state", 32'(dbg_state), 32'd1);
      check("accept_enc_in", 32'(enc_in), 32'(k));
      check_rot("accept_prestep");
      check("accept_key_ready", 32'(kif.key_ready), 32'd0);
      m_enc = int'(k);
      model_step();
      exp_q.push_back(er);
      tick();
      check_rot("step");
      check("step_out_valid", 32'(kif.out_valid), 32'd0);
      lat = 1;
      while (kif.out_valid !== 1'b1 && lat < 40) begin
        tick();
        lat++;
      end
      check("latency", 32'(lat), 32'(SETTLE + 2));
      check("out_letter", 32'(kif.out_letter), 32'(exp_q.pop_front()));
      check_rot("result");
      check("result_key_ready", 32'(kif.key_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
        if (storm) begin
          enc_result    = 5'($urandom_range(0, 31));
          kif.key_valid = 1'($urandom_range(0, 1));
          kif.key_in    = 5'($urandom_range(0, 31));
          load          = 1'($urandom_range(0, 1));
          load_pos1     = 5'($urandom_range(0, 31));
          load_pos2     = 5'($urandom_range(0, 31));
          load_pos3     = 5'($urandom_range(0, 31));
        end
        tick();
        check("hold_out_valid", 32'(kif.out_valid), 32'd1);
        check("hold_out_letter", 32'(kif.out_letter), 32'(er));
        check("hold_state", 32'(dbg_state), 32'd3);
        check("hold_enc_in", 32'(enc_in), 32'(m_enc));
        check_rot("hold");
      end
      load          = 1'b0;
      kif.key_valid = 1'b0;
      kif.out_ready = 1'b1;
      tick();
      kif.out_ready = 1'b0;
      check("done_out_valid", 32'(kif.out_valid), 32'd0);
      check("done_key_ready", 32'(kif.key_ready), 32'd1);
    end else begin
      check("bad_err", 32'(err_invalid), 32'd1);
      check("bad_state", 32'(dbg_state), 32'd0);
      check("bad_enc_in", 32'(enc_in), 32'(m_enc));
      check_rot("bad");
      tick();
      check("bad_err_drop", 32'(err_invalid), 32'd0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
    check({tag, "_rot1"}, 32'(rot1), 32'd0);
    check({tag, "_rot2"}, 32'(rot2), 32'd0);
    check({tag, "_rot3"}, 32'(rot3), 32'd0);
    check({tag, "_enc_in"}, 32'(enc_in), 32'd0);
    check({tag, "_out_letter"}, 32'(kif.out_letter), 32'd0);
    check({tag, "_out_valid"}, 32'(kif.out_valid), 32'd0);
    check({tag, "_err"}, 32'(err_invalid), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    load          = 1'b0;
    load_pos1     = 5'd0;
    load_pos2     = 5'd0;
    load_pos3     = 5'd0;
    kif.key_valid = 1'b0;
    kif.key_in    = 5'd0;
    kif.out_ready = 1'b0;
    enc_result    = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_values("reset");
    check("reset_key_ready", 32'(kif.key_ready), 32'd1);

    // First key after reset, result tied to 7, short backpressure
    do_key(5'd1, 5'd7, 2, 1'b0);

    // Notch carries
    do_load(5'd16, 5'd0, 5'd0);
    do_key(5'd5, 5'd12, 0, 1'b0);
    do_load(5'd16, 5'd4, 5'd0);
    do_key(5'd5, 5'd20, 1, 1'b0);
    do_load(5'd25, 5'd4, 5'd0);
    do_key(5'd1, 5'd3, 0, 1'b0);

    // Invalid keys, and a load value folded from 26..31
    do_key(5'd0, 5'd9, 0, 1'b0);
    do_key(5'd27, 5'd9, 0, 1'b0);
    do_load(5'd31, 5'd26, 5'd29);

    // Ten cycles of backpressure with ignored inputs toggling
    do_key(5'd3, 5'd9, 10, 1'b1);

    // Asynchronous reset during SETTLE
    do_load(5'd3, 5'd3, 5'd3);
    wait_ready();
    kif.key_valid = 1'b1;
    kif.key_in    = 5'd2;
    tick();
    kif.key_valid = 1'b0;
    tick();
    check("pre_reset_state", 32'(dbg_state), 32'd2);
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    #2;
    rst_n = 1'b1;
    m_r1  = 0;
    m_r2  = 0;
    m_r3  = 0;
    m_enc = 0;
    do_key(5'd14, 5'd21, 0, 1'b0);
    check("post_reset_r1", 32'(m_r1), 32'd1);

    // Randomized mix
    for (int i = 0; i < 60; i++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op < 2) begin
        do_load(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)));
      end else if (op < 3) begin
        do_key(5'($urandom_range(0, 1) == 0 ? 0 : $urandom_range(27, 31)),
               5'($urandom_range(0, 31)), 0, 1'b0);
      end else begin
        do_key(5'($urandom_range(1, 26)), 5'($urandom_range(1, 26)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
